// File: rtl/prim_sparse_fsm_pkg.sv
// ============================================================================
//  Module      : prim_sparse_fsm_pkg
//  Description : Shared types and constant helper functions for the hardened
//                sparse-FSM state register and its legality checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prim_sparse_fsm_pkg;

    // Upper bounds that size the flattened arguments of the constant helpers.
    localparam int c_MAX_WIDTH      = 64;
    localparam int c_MAX_STATES     = 32;
    localparam int c_MAX_TABLE_BITS = c_MAX_WIDTH * c_MAX_STATES;

    // Cause of the fault that drove the guard into its terminal state.
    typedef enum logic [1:0] {
        FaultNone     = 2'd0,
        FaultIllegal  = 2'd1,
        FaultMismatch = 2'd2,
        FaultEscalate = 2'd3
    } fault_cause_e;

    // Number of differing bits between two (zero-extended) encodings.
    function automatic int hamming_dist(input logic [c_MAX_WIDTH-1:0] a,
                                        input logic [c_MAX_WIDTH-1:0] b);
        int cnt;
        cnt = 0;
        for (int k = 0; k < c_MAX_WIDTH; k++) begin
            if (a[k] != b[k]) cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // Extracts entry idx of a flattened table whose entries are width bits wide.
    function automatic logic [c_MAX_WIDTH-1:0] get_entry(input logic [c_MAX_TABLE_BITS-1:0] tbl,
                                                         input int width,
                                                         input int idx);
        logic [c_MAX_WIDTH-1:0] ent;
        ent = '0;
        for (int b = 0; b < width; b++) begin
            ent[b] = tbl[idx*width + b];
        end
        return ent;
    endfunction

    // True when value matches one of the first num entries of the table.
    function automatic logic in_table(input logic [c_MAX_TABLE_BITS-1:0] tbl,
                                      input int num,
                                      input int width,
                                      input logic [c_MAX_WIDTH-1:0] value);
        logic found;
        found = 1'b0;
        for (int i = 0; i < num; i++) begin
            if (get_entry(tbl, width, i) == value) found = 1'b1;
        end
        return found;
    endfunction

    // Smallest pairwise distance over the table entries plus the terminal value.
    function automatic int min_pair_hd(input logic [c_MAX_TABLE_BITS-1:0] tbl,
                                       input int num,
                                       input int width,
                                       input logic [c_MAX_WIDTH-1:0] terminal);
        int best;
        int d;
        best = c_MAX_WIDTH;
        for (int i = 0; i < num; i++) begin
            d = hamming_dist(get_entry(tbl, width, i), terminal);
            if (d < best) best = d;
            for (int j = i + 1; j < num; j++) begin
                d = hamming_dist(get_entry(tbl, width, i), get_entry(tbl, width, j));
                if (d < best) best = d;
            end
        end
        return best;
    endfunction

    // True when no two table entries are identical.
    function automatic logic all_distinct(input logic [c_MAX_TABLE_BITS-1:0] tbl,
                                          input int num,
                                          input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < num; i++) begin
            for (int j = i + 1; j < num; j++) begin
                if (get_entry(tbl, width, i) == get_entry(tbl, width, j)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prim_sparse_fsm_legal_chk.sv
// ============================================================================
//  Module      : prim_sparse_fsm_legal_chk
//  Description : Combinational membership check of an encoding against the
//                table of legal sparse-FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_sparse_fsm_legal_chk
    import prim_sparse_fsm_pkg::*;
#(
    parameter int                              Width          = 8,
    parameter int                              NumStates      = 4,
    parameter logic [NumStates-1:0][Width-1:0] StateEncodings = {8'hCC, 8'h33, 8'hF0, 8'h0F}
) (
    input  logic [Width-1:0] state_i,
    output logic             legal_o
);

    logic [NumStates-1:0] w_match;

    // One comparator per legal encoding; the value is legal if any one hits.
    for (genvar i = 0; i < NumStates; i++) begin : g_match
        assign w_match[i] = (state_i == StateEncodings[i]);
    end

    assign legal_o = |w_match;

endmodule

`default_nettype wire

// File: rtl/prim_sparse_fsm_guard.sv
// ============================================================================
//  Module      : prim_sparse_fsm_guard
//  Description : Hardened sparse-FSM state register with optional inverted
//                shadow copy. Illegal encodings, rail mismatch or external
//                escalation lock the register into a terminal encoding that
//                only reset can leave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_sparse_fsm_guard
    import prim_sparse_fsm_pkg::*;
#(
    parameter int                              Width                 = 8,
    parameter int                              NumStates             = 4,
    parameter logic [NumStates-1:0][Width-1:0] StateEncodings        = {8'hCC, 8'h33, 8'hF0, 8'h0F},
    parameter logic [Width-1:0]                ResetValue            = 8'h0F,
    parameter logic [Width-1:0]                TerminalValue         = 8'hAA,
    parameter bit                              DualRail              = 1'b1,
    parameter int                              MinHd                 = 3,
    parameter bit                              EnableAlertTriggerSVA = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] state_i,
    input  logic             escalate_i,
    output logic [Width-1:0] state_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             err_pulse_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time checks on the encoding table
    // ------------------------------------------------------------------------
    localparam logic [c_MAX_TABLE_BITS-1:0] c_TABLE_EXT    = c_MAX_TABLE_BITS'(StateEncodings);
    localparam logic [c_MAX_WIDTH-1:0]      c_RESET_EXT    = c_MAX_WIDTH'(ResetValue);
    localparam logic [c_MAX_WIDTH-1:0]      c_TERMINAL_EXT = c_MAX_WIDTH'(TerminalValue);

    if (Width > c_MAX_WIDTH || NumStates > c_MAX_STATES || NumStates < 1) begin : g_chk_size
        $fatal(1, "prim_sparse_fsm_guard: Width/NumStates outside supported range");
    end
    if (!in_table(c_TABLE_EXT, NumStates, Width, c_RESET_EXT)) begin : g_chk_reset
        $fatal(1, "prim_sparse_fsm_guard: ResetValue not in StateEncodings");
    end
    if (in_table(c_TABLE_EXT, NumStates, Width, c_TERMINAL_EXT)) begin : g_chk_terminal
        $fatal(1, "prim_sparse_fsm_guard: TerminalValue must not be in StateEncodings");
    end
    if (!all_distinct(c_TABLE_EXT, NumStates, Width)) begin : g_chk_distinct
        $fatal(1, "prim_sparse_fsm_guard: StateEncodings entries are not distinct");
    end
    if (min_pair_hd(c_TABLE_EXT, NumStates, Width, c_TERMINAL_EXT) < MinHd) begin : g_chk_hd
        $fatal(1, "prim_sparse_fsm_guard: pairwise Hamming distance below MinHd");
    end
    if (EnableAlertTriggerSVA > 1'b1) begin : g_chk_sva_param
        $fatal(1, "prim_sparse_fsm_guard: EnableAlertTriggerSVA must be 0 or 1");
    end

    // ------------------------------------------------------------------------
    // Registers and fault detection
    // ------------------------------------------------------------------------
    logic [Width-1:0] r_state;
    logic             r_locked;
    logic             r_err;
    logic             r_err_pulse;

    logic             w_legal;
    logic             w_illegal;
    logic             w_mismatch;
    logic             w_fault;
    logic             w_lock_next;
    logic             w_err_cause;
    fault_cause_e     w_cause;

    prim_sparse_fsm_legal_chk #(
        .Width          (Width),
        .NumStates      (NumStates),
        .StateEncodings (StateEncodings)
    ) u_legal_chk (
        .state_i (r_state),
        .legal_o (w_legal)
    );

    // The terminal encoding is not in the table but is a valid resting value.
    assign w_illegal   = !w_legal && (r_state != TerminalValue);
    assign w_fault     = w_illegal || w_mismatch || escalate_i;
    assign w_lock_next = r_locked || w_fault;

    // Highest-priority cause; escalation only counts when nothing else fired.
    always_comb begin
        w_cause = FaultNone;
        if (w_illegal)       w_cause = FaultIllegal;
        else if (w_mismatch) w_cause = FaultMismatch;
        else if (escalate_i) w_cause = FaultEscalate;
    end

    assign w_err_cause = (w_cause == FaultIllegal) || (w_cause == FaultMismatch);

    if (DualRail) begin : g_dual_rail
        logic [Width-1:0] r_shadow;

        // Inverted copy of the primary register, following the same precedence.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_shadow <= ~ResetValue;
            end else if (w_lock_next) begin
                r_shadow <= ~TerminalValue;
            end else if (en_i) begin
                r_shadow <= ~state_i;
            end
        end

        assign w_mismatch = (r_state != ~r_shadow);
    end else begin : g_single_rail
        assign w_mismatch = 1'b0;
    end

    // Primary state, lock flag and fault flags: reset > lock/fault > load > hold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ResetValue;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_fault && !r_locked;
            if (w_lock_next) begin
                r_state  <= TerminalValue;
                r_locked <= 1'b1;
                r_err    <= r_err || w_err_cause;
            end else if (en_i) begin
                r_state  <= state_i;
            end
        end
    end

    // Zero-latency override so the parent never decodes an illegal value.
    assign state_o     = w_lock_next ? TerminalValue : r_state;
    assign locked_o    = r_locked;
    assign err_o       = r_err;
    assign err_pulse_o = r_err_pulse;

`ifdef INC_ASSERT
    logic w_out_legal;

    prim_sparse_fsm_legal_chk #(
        .Width          (Width),
        .NumStates      (NumStates),
        .StateEncodings (StateEncodings)
    ) u_out_chk (
        .state_i (state_o),
        .legal_o (w_out_legal)
    );

    a_lock_sticky : assert property (@(posedge clk_i) $fell(r_locked) |-> $past(!rst_ni));
    a_out_legal   : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     w_out_legal || (state_o == TerminalValue));

    if (EnableAlertTriggerSVA) begin : g_alert_sva
        a_err_alert : assert property (@(posedge clk_i) disable iff (!rst_ni) err_o |-> locked_o);
    end
`endif

endmodule

`default_nettype wire

// File: doc/prim_sparse_fsm_guard.md
Name: prim_sparse_fsm_guard

Overview:
- Hardened sparse-FSM state register. It is the successor to the single-flop sparse state holder.
- It generalises to an N-state legal-encoding table, with an optional dual-rail (inverted shadow) copy.
- It checks legality every cycle in hardware, not only in simulation. On any fault it locks into a terminal state that only reset can leave.
- Instantiated by security-relevant FSMs (LC, key manager, debug control), between their next-state logic and their case statement.

Parameters:
- Width, 8, state encoding width in bits.
- NumStates, 4, number of legal (non-terminal) encodings.
- StateEncodings, {8'hCC,8'h33,8'hF0,8'h0F}, packed [NumStates-1:0][Width-1:0] table of legal encodings; index 0 is 8'h0F.
- ResetValue, 8'h0F, reset encoding; must appear in StateEncodings.
- TerminalValue, 8'hAA, lock encoding; must not appear in StateEncodings.
- DualRail, 1, 1 = keep an inverted shadow register and compare it against the primary.
- MinHd, 3, required minimum pairwise Hamming distance over StateEncodings plus TerminalValue.
- EnableAlertTriggerSVA, 1, enables the assertion that err_o is routed to an alert.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous, active-low reset.
- en_i  input  1  load state_i this cycle.
- state_i  input  Width  next-state from the parent FSM.
- escalate_i  input  1  external escalation; forces lock.
- state_o  output  Width  state presented to the parent FSM.
- locked_o  output  1  registered lock flag.
- err_o  output  1  sticky fault flag, equal to locked_o && !escalation-only cause.
- err_pulse_o  output  1  one-cycle pulse in the cycle lock is entered.

Behaviour:
- Reset: rst_ni sampled low at posedge sets the following values, which hold the cycle after:
  - primary register = ResetValue;
  - shadow register = ~ResetValue;
  - locked_o = 0, err_o = 0, err_pulse_o = 0.
  - Reset mid-lock clears the lock.
- Fault sources, all evaluated combinationally on the registered values:
  - illegal = primary not in StateEncodings and not equal to TerminalValue;
  - mismatch = DualRail && (primary != ~shadow);
  - fault = illegal | mismatch | escalate_i.
- state_o = TerminalValue when locked_q or fault; otherwise primary. The override has zero latency, so the parent never decodes an illegal value.
- Next-state precedence: reset > (locked_q | fault) > en_i > hold.
  - Lock/fault: primary <= TerminalValue, shadow <= ~TerminalValue, locked_q <= 1.
  - en_i: primary <= state_i, shadow <= ~state_i.
  - Hold: registers keep their value.
- While locked, en_i and state_i are ignored. Corruption of the registers while locked keeps the lock; no re-pulse is generated.
- err_pulse_o = fault && !locked_q, registered, so it is high exactly the cycle locked_o first reads 1.
- err_o follows the fault cause:
  - It sets when the locking fault included illegal or mismatch, and stays sticky until reset.
  - Escalation-only lock sets locked_o but not err_o.
  - If illegal or mismatch occurs later while already locked, err_o sets.
- state_i carrying an illegal encoding with en_i=1 is accepted into the register and detected the following cycle (1-cycle latency to lock).
- Simultaneous escalate_i and en_i: escalation wins.
- DualRail=0: the shadow is removed and mismatch is tied to 0.
- Elaboration-time checks (fatal error on failure):
  - ResetValue is in the table;
  - TerminalValue is not in the table;
  - all encodings are distinct;
  - pairwise Hamming distance >= MinHd.
- SVA under INC_ASSERT:
  - locked_o never falls without reset;
  - state_o is always in the table or equals TerminalValue;
  - alert-connection check gated by EnableAlertTriggerSVA.

Decomposition:
- Package prim_sparse_fsm_pkg holds:
  - the fault-cause enum (FaultNone, FaultIllegal, FaultMismatch, FaultEscalate);
  - the hamming_dist() and in_table() constant functions used by both the RTL and the elaboration checks.
- One sub-module, prim_sparse_fsm_legal_chk: purely combinational membership check of Width bits against the table. It is reused by the parent-FSM coverage monitors.
- Registers are local to prim_sparse_fsm_guard, because the reset is synchronous.

Test Plan (all with default parameters):
- Reset then idle: rst_ni low 2 cycles, release -> state_o=8'h0F, locked_o=0, err_o=0, err_pulse_o=0.
- Legal walk: en_i=1 with state_i 8'hF0, 8'h33, 8'hCC on consecutive cycles -> state_o follows with 1-cycle latency; no flag ever asserts.
- Illegal load: en_i=1, state_i=8'h0E -> next cycle state_o=8'hAA combinationally; the following cycle locked_o=1, err_o=1, and err_pulse_o=1 for exactly one cycle.
- Shadow bit-flip: force shadow bit0 while primary=8'h33 -> state_o=8'hAA in the same cycle; lock and err_o=1 next cycle; en_i=1, state_i=8'hF0 afterwards -> state_o stays 8'hAA.
- Escalation with simultaneous load: escalate_i=1 and en_i=1, state_i=8'hF0 -> state_o=8'hAA; then locked_o=1, err_o=0, err_pulse_o pulses once.
- Reset out of lock: while locked, rst_ni low 1 cycle -> state_o=8'h0F, all flags 0; a subsequent legal load of 8'hCC is accepted.
